// File: rtl/move_list_sequencer.sv
// move_list_sequencer
//   Hands one board position to a move generator, waits for its move list, reads the
//   list back one entry at a time (address, then registered RAM data) and streams each
//   resulting board over a valid/ready port. The list is always released with a single
//   clear pulse, and a one-cycle done pulse reports the outcome.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   i_start, i_start_*     job request (sampled only while idle)
//   i_abort, o_busy        cancel current job, job in progress
//   o_gen_*, i_gen_*       generator launch/read/clear handshake and move RAM read data
//   o_mv_*, i_mv_ready     move stream; o_mv_last marks the final move of the list
//   o_done, o_done_*       completion pulse with move count, empty-list and aborted flags
module move_list_sequencer #(
    parameter int unsigned BOARD_WIDTH        = 512,
    parameter int unsigned MAX_POSITIONS      = 256,
    parameter int unsigned MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [BOARD_WIDTH-1:0]        i_start_board,
    input  logic                          i_start_white_to_move,
    input  logic [3:0]                    i_start_castle_mask,
    input  logic [3:0]                    i_start_en_passant_col,
    input  logic                          i_abort,
    output logic                          o_busy,
    output logic                          o_gen_board_valid,
    output logic [BOARD_WIDTH-1:0]        o_gen_board,
    output logic                          o_gen_white_to_move,
    output logic [3:0]                    o_gen_castle_mask,
    output logic [3:0]                    o_gen_en_passant_col,
    output logic [MAX_POSITIONS_LOG2-1:0] o_gen_move_index,
    output logic                          o_gen_clear_moves,
    input  logic                          i_gen_moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] i_gen_move_count,
    input  logic [BOARD_WIDTH-1:0]        i_gen_board_out,
    input  logic                          i_gen_white_to_move_out,
    input  logic [3:0]                    i_gen_castle_mask_out,
    input  logic [3:0]                    i_gen_en_passant_col_out,
    output logic                          o_mv_valid,
    input  logic                          i_mv_ready,
    output logic [BOARD_WIDTH-1:0]        o_mv_board,
    output logic                          o_mv_white_to_move,
    output logic [3:0]                    o_mv_castle_mask,
    output logic [3:0]                    o_mv_en_passant_col,
    output logic                          o_mv_last,
    output logic                          o_done,
    output logic [MAX_POSITIONS_LOG2-1:0] o_done_count,
    output logic                          o_done_no_moves,
    output logic                          o_done_aborted
);

    localparam int unsigned W = MAX_POSITIONS_LOG2;

    typedef enum logic [2:0] {
        StIdle, StLaunch, StWaitGen, StAddr, StRd, StOffer, StClear, StDrain
    } state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_abort_pending;
    logic [W-1:0]           r_index;
    logic [W-1:0]           r_done_count;
    logic                   r_gen_board_valid;
    logic                   r_gen_clear_moves;
    logic [BOARD_WIDTH-1:0] r_gen_board;
    logic                   r_gen_white_to_move;
    logic [3:0]             r_gen_castle_mask;
    logic [3:0]             r_gen_en_passant_col;
    logic                   r_mv_valid;
    logic                   r_mv_last;
    logic [BOARD_WIDTH-1:0] r_mv_board;
    logic                   r_mv_white_to_move;
    logic [3:0]             r_mv_castle_mask;
    logic [3:0]             r_mv_en_passant_col;
    logic                   r_done;
    logic                   r_done_no_moves;
    logic                   r_done_aborted;

    logic         w_abort_now;
    logic [W-1:0] w_last_index;

    assign w_abort_now  = r_abort_pending | i_abort;
    assign w_last_index = r_done_count - W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state              <= StIdle;
            r_busy               <= 1'b0;
            r_abort_pending      <= 1'b0;
            r_index              <= '0;
            r_done_count         <= '0;
            r_gen_board_valid    <= 1'b0;
            r_gen_clear_moves    <= 1'b0;
            r_gen_board          <= '0;
            r_gen_white_to_move  <= 1'b0;
            r_gen_castle_mask    <= '0;
            r_gen_en_passant_col <= '0;
            r_mv_valid           <= 1'b0;
            r_mv_last            <= 1'b0;
            r_mv_board           <= '0;
            r_mv_white_to_move   <= 1'b0;
            r_mv_castle_mask     <= '0;
            r_mv_en_passant_col  <= '0;
            r_done               <= 1'b0;
            r_done_no_moves      <= 1'b0;
            r_done_aborted       <= 1'b0;
        end else begin
            // Single-cycle strobes
            r_gen_board_valid <= 1'b0;
            r_gen_clear_moves <= 1'b0;
            r_done            <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_gen_board          <= i_start_board;
                        r_gen_white_to_move  <= i_start_white_to_move;
                        r_gen_castle_mask    <= i_start_castle_mask;
                        r_gen_en_passant_col <= i_start_en_passant_col;
                        r_gen_board_valid    <= 1'b1;
                        r_busy               <= 1'b1;
                        r_state              <= StLaunch;
                    end
                end
                StLaunch: begin
                    if (i_abort) r_abort_pending <= 1'b1;
                    r_state <= StWaitGen;
                end
                StWaitGen: begin
                    if (i_abort) r_abort_pending <= 1'b1;
                    // Generator only returns to idle through a clear, so even an
                    // aborted job waits here for the list to be ready.
                    if (i_gen_moves_ready) begin
                        r_done_count <= i_gen_move_count;
                        if (i_gen_move_count == '0 || w_abort_now) begin
                            r_gen_clear_moves <= 1'b1;
                            r_state           <= StClear;
                        end else begin
                            r_index <= '0;
                            r_state <= StAddr;
                        end
                    end
                end
                StAddr: begin
                    if (i_abort) begin
                        r_abort_pending   <= 1'b1;
                        r_gen_clear_moves <= 1'b1;
                        r_state           <= StClear;
                    end else begin
                        r_state <= StRd;
                    end
                end
                StRd: begin
                    if (i_abort) begin
                        r_abort_pending   <= 1'b1;
                        r_gen_clear_moves <= 1'b1;
                        r_state           <= StClear;
                    end else begin
                        // RAM data for r_index is valid this cycle
                        r_mv_board          <= i_gen_board_out;
                        r_mv_white_to_move  <= i_gen_white_to_move_out;
                        r_mv_castle_mask    <= i_gen_castle_mask_out;
                        r_mv_en_passant_col <= i_gen_en_passant_col_out;
                        r_mv_last           <= (r_index == w_last_index);
                        r_mv_valid          <= 1'b1;
                        r_state             <= StOffer;
                    end
                end
                StOffer: begin
                    if (i_abort) r_abort_pending <= 1'b1;
                    // A handshake coinciding with abort still counts as delivered.
                    if (i_mv_ready) begin
                        r_mv_valid <= 1'b0;
                        r_mv_last  <= 1'b0;
                        if (r_mv_last || i_abort) begin
                            r_gen_clear_moves <= 1'b1;
                            r_state           <= StClear;
                        end else begin
                            r_index <= r_index + W'(1);
                            r_state <= StAddr;
                        end
                    end else if (i_abort) begin
                        r_mv_valid        <= 1'b0;
                        r_mv_last         <= 1'b0;
                        r_gen_clear_moves <= 1'b1;
                        r_state           <= StClear;
                    end
                end
                StClear: begin
                    r_state <= StDrain;
                end
                StDrain: begin
                    if (!i_gen_moves_ready) begin
                        r_done          <= 1'b1;
                        r_done_no_moves <= (r_done_count == '0);
                        r_done_aborted  <= r_abort_pending;
                        r_abort_pending <= 1'b0;
                        r_busy          <= 1'b0;
                        r_state         <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy               = r_busy;
    assign o_gen_board_valid    = r_gen_board_valid;
    assign o_gen_board          = r_gen_board;
    assign o_gen_white_to_move  = r_gen_white_to_move;
    assign o_gen_castle_mask    = r_gen_castle_mask;
    assign o_gen_en_passant_col = r_gen_en_passant_col;
    assign o_gen_move_index     = r_index;
    assign o_gen_clear_moves    = r_gen_clear_moves;
    assign o_mv_valid           = r_mv_valid;
    assign o_mv_board           = r_mv_board;
    assign o_mv_white_to_move   = r_mv_white_to_move;
    assign o_mv_castle_mask     = r_mv_castle_mask;
    assign o_mv_en_passant_col  = r_mv_en_passant_col;
    assign o_mv_last            = r_mv_last;
    assign o_done               = r_done;
    assign o_done_count         = r_done_count;
    assign o_done_no_moves      = r_done_no_moves;
    assign o_done_aborted       = r_done_aborted;

endmodule

// File: tb/tb_move_list_sequencer.sv
// Directed bench for move_list_sequencer with a behavioural move generator
// (fixed-latency list build, registered RAM read, ready drops one cycle after clear).
module tb_move_list_sequencer;

    localparam int BW = 512;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start_wtm, abort, busy;
    logic [BW-1:0] start_board;
    logic [3:0]    start_castle, start_ep;
    logic          gen_board_valid, gen_wtm, gen_clear_moves, gen_moves_ready;
    logic [BW-1:0] gen_board, gen_board_out;
    logic [3:0]    gen_castle, gen_ep, gen_castle_out, gen_ep_out;
    logic [W-1:0]  gen_move_index, gen_move_count;
    logic          gen_wtm_out;
    logic          mv_valid, mv_ready, mv_wtm, mv_last;
    logic [BW-1:0] mv_board;
    logic [3:0]    mv_castle, mv_ep;
    logic          done, done_no_moves, done_aborted;
    logic [W-1:0]  done_count;

    always #5 clk = ~clk;

    move_list_sequencer #(.BOARD_WIDTH(BW), .MAX_POSITIONS(256)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .i_start                  (start),
        .i_start_board            (start_board),
        .i_start_white_to_move    (start_wtm),
        .i_start_castle_mask      (start_castle),
        .i_start_en_passant_col   (start_ep),
        .i_abort                  (abort),
        .o_busy                   (busy),
        .o_gen_board_valid        (gen_board_valid),
        .o_gen_board              (gen_board),
        .o_gen_white_to_move      (gen_wtm),
        .o_gen_castle_mask        (gen_castle),
        .o_gen_en_passant_col     (gen_ep),
        .o_gen_move_index         (gen_move_index),
        .o_gen_clear_moves        (gen_clear_moves),
        .i_gen_moves_ready        (gen_moves_ready),
        .i_gen_move_count         (gen_move_count),
        .i_gen_board_out          (gen_board_out),
        .i_gen_white_to_move_out  (gen_wtm_out),
        .i_gen_castle_mask_out    (gen_castle_out),
        .i_gen_en_passant_col_out (gen_ep_out),
        .o_mv_valid               (mv_valid),
        .i_mv_ready               (mv_ready),
        .o_mv_board               (mv_board),
        .o_mv_white_to_move       (mv_wtm),
        .o_mv_castle_mask         (mv_castle),
        .o_mv_en_passant_col      (mv_ep),
        .o_mv_last                (mv_last),
        .o_done                   (done),
        .o_done_count             (done_count),
        .o_done_no_moves          (done_no_moves),
        .o_done_aborted           (done_aborted)
    );

    // Generator RAM contents as a function of list index
    function automatic logic [BW-1:0] exp_board(input int i);
        logic [31:0] word;
        word = 32'hC0DE_0000 | i;
        return {16{word}};
    endfunction
    function automatic logic exp_wtm(input int i);
        return i[0];
    endfunction
    function automatic logic [3:0] exp_castle(input int i);
        return i[3:0] ^ 4'hA;
    endfunction
    function automatic logic [3:0] exp_ep(input int i);
        return 4'(i + 1);
    endfunction

    // ---------------- generator model ----------------
    int         model_count = 0;
    logic [3:0] g_cnt;
    logic       g_clr;

    always @(posedge clk) begin
        if (reset) begin
            gen_moves_ready <= 1'b0;
            gen_move_count  <= '0;
            g_cnt           <= 4'd0;
            g_clr           <= 1'b0;
        end else begin
            if (gen_board_valid) begin
                g_cnt <= 4'd3;
            end else if (g_cnt != 4'd0) begin
                g_cnt <= g_cnt - 4'd1;
                if (g_cnt == 4'd1) begin
                    gen_moves_ready <= 1'b1;
                    gen_move_count  <= W'(model_count);
                end
            end
            if (gen_clear_moves) begin
                g_clr <= 1'b1;
            end else if (g_clr) begin
                g_clr           <= 1'b0;
                gen_moves_ready <= 1'b0;
            end
        end
        gen_board_out  <= exp_board(int'(gen_move_index));
        gen_wtm_out    <= exp_wtm(int'(gen_move_index));
        gen_castle_out <= exp_castle(int'(gen_move_index));
        gen_ep_out     <= exp_ep(int'(gen_move_index));
    end

    // ---------------- stream / status monitor ----------------
    int              hs_count = 0, data_err = 0, last_err = 0, last_cnt = 0;
    int              stab_err = 0, stall_cnt = 0, clr_cnt = 0, done_cnt = 0;
    int              gbv_cnt = 0, valid_cnt = 0, job_idx = 0, job_count = 0;
    logic            prev_stall = 1'b0;
    logic [BW+9:0]   held;

    always @(negedge clk) begin
        if (gen_board_valid) begin
            job_idx   <= 0;
            job_count <= model_count;
            gbv_cnt   <= gbv_cnt + 1;
        end
        if (mv_valid) valid_cnt <= valid_cnt + 1;
        if (mv_valid && !mv_ready) stall_cnt <= stall_cnt + 1;
        if (mv_valid && prev_stall && {mv_board, mv_wtm, mv_castle, mv_ep, mv_last} !== held)
            stab_err <= stab_err + 1;
        prev_stall <= mv_valid && !mv_ready;
        held       <= {mv_board, mv_wtm, mv_castle, mv_ep, mv_last};
        if (mv_valid && mv_ready) begin
            if (mv_board !== exp_board(job_idx) || mv_wtm !== exp_wtm(job_idx) ||
                mv_castle !== exp_castle(job_idx) || mv_ep !== exp_ep(job_idx))
                data_err <= data_err + 1;
            if (mv_last !== (job_idx == job_count - 1)) last_err <= last_err + 1;
            if (mv_last) last_cnt <= last_cnt + 1;
            job_idx  <= job_idx + 1;
            hs_count <= hs_count + 1;
        end
        if (gen_clear_moves) clr_cnt <= clr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rdy_mode == 1) mv_ready = (cyc % 3 == 0);
    endtask

    task automatic pulse_start(input logic [BW-1:0] b, input logic w, input logic [3:0] c,
                               input logic [3:0] e);
        start_board  = b;
        start_wtm    = w;
        start_castle = c;
        start_ep     = e;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (mv_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    logic [BW-1:0] init_board, board_a, board_b;
    int  b_hs, b_last, b_clr, b_valid, b_stall, b_gbv, b_done;
    bit  ok;

    initial begin
        init_board = {64'h0C0A_0B0E_0D0B_0A0C, 64'h0909_0909_0909_0909, {4{64'h0}},
                      64'h0101_0101_0101_0101, 64'h0402_0306_0503_0204};
        board_a    = {8{64'h1111_2222_3333_4444}};
        board_b    = {8{64'h5555_6666_7777_8888}};
        reset = 1'b1; start = 1'b0; abort = 1'b0; mv_ready = 1'b0;
        start_board = '0; start_wtm = 1'b0; start_castle = '0; start_ep = '0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mv_valid", mv_valid, 0);
        chk("rst_mv_last", mv_last, 0);
        chk("rst_done", done, 0);
        chk("rst_no_moves", done_no_moves, 0);
        chk("rst_aborted", done_aborted, 0);
        chk("rst_gbv", gen_board_valid, 0);
        chk("rst_clear", gen_clear_moves, 0);
        chk("rst_move_index", gen_move_index, 0);
        chk("rst_done_count", done_count, 0);
        reset = 1'b0;
        tick();

        // Initial position: 20 moves, sink always ready
        model_count = 20; mv_ready = 1'b1;
        b_hs = hs_count; b_last = last_cnt; b_clr = clr_cnt;
        pulse_start(init_board, 1'b1, 4'hF, 4'h8);
        @(negedge clk);
        chk("a_gbv", gen_board_valid, 1);
        chk("a_gen_board", gen_board, init_board);
        chk("a_gen_wtm", gen_wtm, 1);
        chk("a_gen_castle", gen_castle, 4'hF);
        chk("a_gen_ep", gen_ep, 4'h8);
        chk("a_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("a_gbv_one_cycle", gen_board_valid, 0);
        wait_done(300, ok);
        chk("a_done_seen", ok, 1);
        chk("a_done_count", done_count, 20);
        chk("a_no_moves", done_no_moves, 0);
        chk("a_aborted", done_aborted, 0);
        chk("a_handshakes", hs_count - b_hs, 20);
        chk("a_last_pulses", last_cnt - b_last, 1);
        chk("a_clear_pulses", clr_cnt - b_clr, 1);
        chk("a_data_err", data_err, 0);
        chk("a_last_err", last_err, 0);
        tick();
        @(negedge clk);
        chk("a_done_one_cycle", done, 0);
        chk("a_idle_busy", busy, 0);

        // Empty move list
        model_count = 0;
        b_clr = clr_cnt; b_valid = valid_cnt;
        pulse_start(board_a, 1'b0, 4'h0, 4'h8);
        wait_done(100, ok);
        chk("b_done_seen", ok, 1);
        chk("b_done_count", done_count, 0);
        chk("b_no_moves", done_no_moves, 1);
        chk("b_aborted", done_aborted, 0);
        chk("b_valid_cycles", valid_cnt - b_valid, 0);
        chk("b_clear_pulses", clr_cnt - b_clr, 1);

        // Five moves, sink ready one cycle in three
        model_count = 5; rdy_mode = 1;
        b_hs = hs_count; b_last = last_cnt; b_stall = stall_cnt;
        pulse_start(board_b, 1'b1, 4'h3, 4'h2);
        wait_done(300, ok);
        rdy_mode = 0; mv_ready = 1'b1;
        chk("c_done_seen", ok, 1);
        chk("c_done_count", done_count, 5);
        chk("c_handshakes", hs_count - b_hs, 5);
        chk("c_stalled", (stall_cnt > b_stall) ? 1 : 0, 1);
        chk("c_stable", stab_err, 0);
        chk("c_data_err", data_err, 0);
        chk("c_last_err", last_err, 0);
        chk("c_last_pulses", last_cnt - b_last, 1);

        // Abort while move 2 of 10 is offered
        model_count = 10; mv_ready = 1'b0;
        b_hs = hs_count; b_clr = clr_cnt;
        pulse_start(board_a, 1'b1, 4'h5, 4'h1);
        wait_valid(100, ok);
        chk("d_first_valid", ok, 1);
        tick(); mv_ready = 1'b1;
        tick(); mv_ready = 1'b0;
        wait_valid(100, ok);
        chk("d_second_valid", ok, 1);
        tick(); abort = 1'b1;
        tick(); abort = 1'b0;
        @(negedge clk);
        chk("d_valid_dropped", mv_valid, 0);
        chk("d_busy", busy, 1);
        wait_done(100, ok);
        chk("d_done_seen", ok, 1);
        chk("d_aborted", done_aborted, 1);
        chk("d_done_count", done_count, 10);
        chk("d_no_moves", done_no_moves, 0);
        chk("d_handshakes", hs_count - b_hs, 1);
        chk("d_clear_pulses", clr_cnt - b_clr, 1);

        // Abort coinciding with a handshake
        model_count = 4;
        b_hs = hs_count; b_clr = clr_cnt;
        pulse_start(board_b, 1'b0, 4'h1, 4'h3);
        wait_valid(100, ok);
        chk("e_valid", ok, 1);
        tick(); mv_ready = 1'b1; abort = 1'b1;
        tick(); mv_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("e_valid_dropped", mv_valid, 0);
        wait_done(100, ok);
        chk("e_done_seen", ok, 1);
        chk("e_aborted", done_aborted, 1);
        chk("e_done_count", done_count, 4);
        chk("e_handshakes", hs_count - b_hs, 1);
        chk("e_clear_pulses", clr_cnt - b_clr, 1);

        // Start while busy is ignored; start the cycle after done is accepted
        model_count = 2; mv_ready = 1'b1;
        b_gbv = gbv_cnt;
        pulse_start(board_a, 1'b1, 4'h7, 4'h4);
        tick(); tick();
        pulse_start(board_b, 1'b0, 4'h2, 4'h6);
        @(negedge clk);
        chk("f_busy_start_gbv", gen_board_valid, 0);
        chk("f_busy_start_board", gen_board, board_a);
        wait_done(100, ok);
        chk("f_done_seen", ok, 1);
        chk("f_one_launch", gbv_cnt - b_gbv, 1);
        tick();
        pulse_start(board_b, 1'b0, 4'h2, 4'h6);
        @(negedge clk);
        chk("f_restart_gbv", gen_board_valid, 1);
        chk("f_restart_board", gen_board, board_b);
        wait_done(100, ok);
        chk("f_second_done", ok, 1);
        chk("f_done_count", done_count, 2);

        // Reset during WAIT_GEN, then a normal job
        model_count = 3;
        pulse_start(board_a, 1'b1, 4'h9, 4'h8);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("g_busy", busy, 0);
        chk("g_gbv", gen_board_valid, 0);
        chk("g_clear", gen_clear_moves, 0);
        chk("g_move_index", gen_move_index, 0);
        chk("g_done_count", done_count, 0);
        chk("g_mv_valid", mv_valid, 0);
        chk("g_done", done, 0);
        b_done = done_cnt;
        repeat (10) tick();
        chk("g_no_done_pulse", done_cnt - b_done, 0);
        b_hs = hs_count;
        pulse_start(board_b, 1'b0, 4'h0, 4'h8);
        wait_done(100, ok);
        chk("g_done_seen", ok, 1);
        chk("g_done_count_after", done_count, 3);
        chk("g_handshakes", hs_count - b_hs, 3);
        chk("g_data_err", data_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
